// File: rtl/fp_issue_pkg.sv
// Shared types and constants for the FP issue controller.
// The typedefs describe the default configuration (OP_W=16, NREG=32).
package fp_issue_pkg;

  localparam int unsigned FpOpW     = 16;
  localparam int unsigned FpNReg    = 32;
  localparam int unsigned FpRw      = $clog2(FpNReg);
  localparam int unsigned FpStatusW = 5;

  // Bit positions inside the IEEE status / fflags vector.
  localparam int unsigned StatusNv = 4;
  localparam int unsigned StatusDz = 3;
  localparam int unsigned StatusOf = 2;
  localparam int unsigned StatusUf = 1;
  localparam int unsigned StatusNx = 0;

  typedef struct packed {
    logic            epoch;
    logic            rd_fp;
    logic [FpRw-1:0] rd;
  } fp_issue_tag_t;

  typedef struct packed {
    logic [FpOpW-1:0]  op;
    logic [3*FpRw-1:0] rs;
    logic [2:0]        rs_used;
    logic [FpRw-1:0]   rd;
    logic              rd_fp;
  } fp_issue_entry_t;

endpackage

// File: rtl/fp_issue_fifo.sv
// Generic synchronous FIFO with push/pop/clear and occupancy count.
// No fall-through: a pushed entry reaches the head on the following cycle.
module fp_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers are PtrW bits wide, so they wrap modulo DEPTH (a power of two).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fp_issue_ctrl.sv
// In-order FP issue controller: issue FIFO, busy scoreboard, outstanding cap,
// tag-routed writeback and epoch-based flush. Optional fflags via FP_ISSUE_FFLAGS_EN.
module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned OP_W    = 16,
  parameter int unsigned FLEN    = 32,
  parameter int unsigned NREG    = 32,
  localparam int unsigned RW     = $clog2(NREG),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [OP_W-1:0]      in_op_i,
  input  logic [3*RW-1:0]      in_rs_i,
  input  logic [2:0]           in_rs_used_i,
  input  logic [RW-1:0]        in_rd_i,
  input  logic                 in_rd_fp_i,
  output logic                 fpu_valid_o,
  input  logic                 fpu_ready_i,
  output logic [OP_W-1:0]      fpu_op_o,
  output logic [3*RW-1:0]      fpu_rs_o,
  output logic [RW+1:0]        fpu_tag_o,
  output logic                 fpu_flush_o,
  input  logic                 fpu_out_valid_i,
  input  logic [RW+1:0]        fpu_tag_i,
  input  logic [FLEN-1:0]      fpu_result_i,
  input  logic [FpStatusW-1:0] fpu_status_i,
`ifdef FP_ISSUE_FFLAGS_EN
  input  logic                 fflags_clr_i,
  output logic [FpStatusW-1:0] fflags_o,
`endif
  output logic                 frf_we_o,
  output logic [RW-1:0]        frf_waddr_o,
  output logic [FLEN-1:0]      frf_wdata_o,
  output logic                 irf_we_o,
  output logic [4:0]           irf_waddr_o,
  output logic [FLEN-1:0]      irf_wdata_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic          epoch;
    logic          rd_fp;
    logic [RW-1:0] rd;
  } tag_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [3*RW-1:0] rs;
    logic [2:0]      rs_used;
    logic [RW-1:0]   rd;
    logic            rd_fp;
  } entry_t;

  localparam int unsigned EntW = $bits(entry_t);

  entry_t            in_entry;
  entry_t            head;
  logic [EntW-1:0]   head_bits;
  logic              empty;
  logic              full;
  logic              push;
  logic              issue;
  logic              hazard;
  logic              accept;
  tag_t              ret_tag;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic [OutW-1:0]   outstanding;
  logic              epoch;
  logic [RW-1:0]     wb_rd;
  logic [FLEN-1:0]   wb_data;

  assign in_entry = '{op: in_op_i, rs: in_rs_i, rs_used: in_rs_used_i,
                      rd: in_rd_i, rd_fp: in_rd_fp_i};
  assign in_ready_o = !full;
  assign push       = in_valid_i && in_ready_o && !flush_i;

  fp_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (issue),
    .clear (flush_i),
    .wdata (in_entry),
    .rdata (head_bits),
    .empty (empty),
    .full  (full),
    .count (count_o)
  );

  assign head = entry_t'(head_bits);

  always_comb begin
    hazard = (outstanding == OutW'(MAX_OUT));
    for (int i = 0; i < 3; i++) begin
      if (head.rs_used[i] && busy[head.rs[i*RW +: RW]]) begin
        hazard = 1'b1;
      end
    end
    if (head.rd_fp && busy[head.rd]) begin
      hazard = 1'b1;
    end
  end

  assign fpu_valid_o = !empty && !hazard && !flush_i;
  assign issue       = fpu_valid_o && fpu_ready_i;
  assign fpu_op_o    = empty ? '0 : head.op;
  assign fpu_rs_o    = empty ? '0 : head.rs;
  assign fpu_tag_o   = empty ? '0 : {epoch, head.rd_fp, head.rd};
  assign fpu_flush_o = flush_i;

  // Results completing in a flush cycle belong to the epoch being discarded.
  assign ret_tag = tag_t'(fpu_tag_i);
  assign accept  = fpu_out_valid_i && (ret_tag.epoch == epoch) && !flush_i;

  always_comb begin
    busy_next = busy;
    if (accept && ret_tag.rd_fp) begin
      busy_next[ret_tag.rd] = 1'b0;
    end
    if (issue && head.rd_fp) begin
      busy_next[head.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy        <= '0;
      outstanding <= '0;
      epoch       <= 1'b0;
      frf_we_o    <= 1'b0;
      irf_we_o    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      frf_we_o <= accept && ret_tag.rd_fp;
      irf_we_o <= accept && !ret_tag.rd_fp;
      if (accept) begin
        wb_rd   <= ret_tag.rd;
        wb_data <= fpu_result_i;
      end
      if (flush_i) begin
        busy        <= '0;
        outstanding <= '0;
        epoch       <= ~epoch;
      end else begin
        busy        <= busy_next;
        outstanding <= outstanding + OutW'(issue) - OutW'(accept);
      end
    end
  end

  assign frf_waddr_o = wb_rd;
  assign frf_wdata_o = wb_data;
  assign irf_waddr_o = 5'(wb_rd);
  assign irf_wdata_o = wb_data;
  assign busy_o      = !empty || (outstanding != '0);

`ifdef FP_ISSUE_FFLAGS_EN
  // A clear coinciding with a completion keeps only the new status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_o <= '0;
    end else if (fflags_clr_i) begin
      fflags_o <= accept ? fpu_status_i : '0;
    end else if (accept) begin
      fflags_o <= fflags_o | fpu_status_i;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^fpu_status_i;
`endif

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Parametrised issue/scoreboard controller between the core's FP decode stage and the fpnew_top datapath.
- Replaces the single-op, always-ready hookup with the following:
  - a DEPTH-entry in-order issue FIFO;
  - a per-FP-register busy scoreboard (RAW/WAW hazards);
  - a cap on outstanding operations;
  - tag-routed writeback to the FP or integer register file;
  - flush with epoch-based discard of stale results.

Parameters:
- DEPTH, 4: issue FIFO entries; power of two, at least 2.
- MAX_OUT, 4: maximum FPU operations in flight, 1..15.
- OP_W, 16: width of the opaque op payload (operator, mod, fmt, rm) forwarded to the FPU.
- FLEN, 32: result width.
- NREG, 32: FP register count; register index width is RW = $clog2(NREG).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- in_valid_i  in  1  decoded FP op offered
- in_ready_o  out  1  FIFO can accept
- in_op_i  in  OP_W  op payload
- in_rs_i  in  3*RW  sources rs3,rs2,rs1 (MSB..LSB)
- in_rs_used_i  in  3  per-source use mask
- in_rd_i  in  RW  destination index
- in_rd_fp_i  in  1  1 = FP destination, 0 = integer destination
- fpu_valid_o  out  1  issue strobe
- fpu_ready_i  in  1  FPU in_ready
- fpu_op_o  out  OP_W  issued payload
- fpu_rs_o  out  3*RW  issued sources (register-file read addresses)
- fpu_tag_o  out  RW+2  {epoch, rd_fp, rd}
- fpu_flush_o  out  1  flush forwarded to the FPU
- fpu_out_valid_i  in  1  FPU result valid (out_ready is tied 1 at the FPU)
- fpu_tag_i  in  RW+2  returned tag
- fpu_result_i  in  FLEN  result
- fpu_status_i  in  5  NV,DZ,OF,UF,NX
- frf_we_o  out  1  FP register-file write enable
- frf_waddr_o  out  RW  FP write address
- frf_wdata_o  out  FLEN  FP write data
- irf_we_o  out  1  integer register-file write enable
- irf_waddr_o  out  5  integer write address
- irf_wdata_o  out  FLEN  integer write data
- flush_i  in  1  pipeline flush
- busy_o  out  1  FIFO non-empty or ops outstanding
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst_i sampled at a clk_i edge, synchronous): all outputs 0; FIFO empty; busy[] all 0; outstanding = 0; epoch = 0. Reset mid-operation discards everything, and no writeback fires in the following cycle.
- Enqueue:
  - in_ready_o = (count < DEPTH), registered-state only, with no combinational path from fpu_ready_i.
  - The entry is written when in_valid_i && in_ready_o.
  - Full with a dequeue in the same cycle: in_ready_o is still 0 that cycle.
  - Empty: a new entry becomes visible at the head in the next cycle; there is no fall-through.
- Issue (head only, in order):
  - Hazard = any used source with busy[rs]=1, or (head.rd_fp && busy[rd]), or outstanding == MAX_OUT.
  - fpu_valid_o = !empty && !hazard && !flush_i.
  - Transfer = fpu_valid_o && fpu_ready_i. On transfer: pop; outstanding++; if rd_fp, set busy[rd].
  - fpu_op_o, fpu_rs_o and fpu_tag_o are driven combinationally from the head and are stable while fpu_valid_o is high.
  - Busy bits use no bypass: a busy bit cleared by a completion in cycle N permits issue at the earliest in cycle N+1.
- Completion:
  - On fpu_out_valid_i with tag epoch == current epoch: outstanding--; if tag.rd_fp, clear busy[rd].
  - The writeback is registered, with 1-cycle latency. In cycle N+1:
    - if rd_fp: frf_we_o=1, frf_waddr_o=rd, frf_wdata_o=result;
    - otherwise: irf_we_o=1, irf_waddr_o=rd, irf_wdata_o=result.
  - Each write-enable pulses for exactly one cycle per result.
  - A tag with a mismatching epoch is dropped: no write, no counter change.
- Simultaneous issue and completion: outstanding is unchanged, and the set and clear act on different registers. The same register cannot be involved, because the WAW check blocks it.
- Flush: flush_i is asserted for one or more cycles.
  - fpu_flush_o = flush_i, combinational.
  - In the flush cycle: no issue; FIFO cleared; busy[] cleared; outstanding = 0; epoch toggles.
  - An enqueue presented in the flush cycle is dropped.
  - A writeback already registered from cycle N-1 still fires.
- Arithmetic: outstanding is $clog2(MAX_OUT+1) bits, with no wrap under legal stimulus. Pointers wrap modulo DEPTH.
- busy_o = !empty || (outstanding != 0).

Optional Feature:
- Macro: FP_ISSUE_FFLAGS_EN.
- When defined:
  - Adds output fflags_o [4:0], a sticky accrued-exception register.
  - On each accepted (epoch-matching) completion, fflags_o |= fpu_status_i, visible the next cycle.
  - Adds input fflags_clr_i, which zeroes the register.
  - If fflags_clr_i and a completion occur in the same cycle, the result is the new status only.
  - Reset value 0; flush does not clear it.
- When undefined: the port and the register are absent and fpu_status_i is ignored.

Decomposition:
- fp_issue_pkg holds:
  - the typedef fp_issue_tag_t {epoch, rd_fp, rd};
  - the typedef fp_issue_entry_t {op, rs, rs_used, rd, rd_fp};
  - the status-bit index constants.
- One sub-module, fp_issue_fifo: a generic DEPTH×entry synchronous FIFO with push/pop/clear and count.
- The scoreboard, counter, epoch and writeback logic stay in the top module.

Test Plan:
- Back-to-back independent ops: fadd f1 then fmul f2, with fpu_ready_i=1 → issue in consecutive cycles. Results with tags {0,1,1} and {0,1,2} → frf_we_o pulses with waddr 1 then 2, one cycle after each out_valid.
- RAW: fadd f3 then fsub f4=f3-f5 → second op held (fpu_valid_o=0) until f3 completes; issues in the cycle after that completion.
- Outstanding cap: MAX_OUT=4, push 6 independent ops, FPU withholding results → exactly 4 transfers. The 5th issues the cycle after the first completion. count_o ends at 1.
- Full FIFO: DEPTH=4, fpu_ready_i=0, push 5 ops → in_ready_o drops after 4 and the 5th is not accepted. count_o=4.
- Flush with 2 ops in flight (epoch 0) → FIFO and busy cleared, epoch=1. Late results with epoch-0 tags → no frf_we_o/irf_we_o, outstanding stays 0, busy_o=0.
- fcvt.w.s to x7 (rd_fp=0) → irf_we_o=1, irf_waddr_o=7, no FP busy bit set. With FP_ISSUE_FFLAGS_EN, statuses 5'b00001 then 5'b10000 → fflags_o=5'b10001.
